// File: rtl/dmem_pkg.sv
// Shared types for the wait-state data memory: FSM states, wait counter, lane math.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   typedef logic [3:0] cnt_t;

   // Number of byte-offset bits in an address for an n-bit word.
   function automatic int laneBits(input int n);
      return $clog2(n / 8);
   endfunction

endpackage

// File: rtl/dmem_wait_if.sv
// Request/response bus between the load/store stage (master) and dmem_wait (slave).
interface dmem_wait_if #(
   parameter int N = 32
) ();

   logic           req_valid;
   logic           req_ready;
   logic           write_enable;
   logic [N-1:0]   addr;
   logic [N-1:0]   writedata;
   logic [N/8-1:0] be;
   logic           resp_valid;
   logic [N-1:0]   readdata;
   logic           err;

   modport master (
      output req_valid, write_enable, addr, writedata, be,
      input  req_ready, resp_valid, readdata, err
   );

   modport slave (
      input  req_valid, write_enable, addr, writedata, be,
      output req_ready, resp_valid, readdata, err
   );

endinterface

// File: rtl/dmem_array.sv
// 2**R x N word store with per-byte-lane write enables and a combinational read port.
module dmem_array #(
   parameter int N = 32,
   parameter int R = 6
) (
   input  logic           clk,
   input  logic [N/8-1:0] we_i,
   input  logic [R-1:0]   addr_i,
   input  logic [N-1:0]   wdata_i,
   output logic [N-1:0]   rdata_o
);

   logic [N-1:0] mem [2**R];

   always_ff @(posedge clk) begin
      for (int i = 0; i < N / 8; i++) begin
         if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
   end

   assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_wait.sv
// Data memory with fixed WAIT-state latency, error flagging and byte-lane writes.
// Define DMEM_BYTE_WRITE_EN to honour be per lane; otherwise every write is full-word.
module dmem_wait
   import dmem_pkg::*;
#(
   parameter int N    = 32,
   parameter int R    = 6,
   parameter int WAIT = 2
) (
   input logic        clk,
   input logic        rst,
   dmem_wait_if.slave bus
);

   localparam int  B        = laneBits(N);
   localparam int  NB       = N / 8;
   localparam bit  ZeroWait = (WAIT == 0);

   state_t          state_q;
   cnt_t            cnt_q;
   logic            we_q;
   logic [N-1:0]    addr_q;
   logic [N-1:0]    wdata_q;
   logic [NB-1:0]   be_q;
   logic            respValid_q;
   logic [N-1:0]    readData_q;
   logic            err_q;

   logic            reqReady;
   logic            accept;
   logic            fire;
   logic            accWe;
   logic [N-1:0]    accAddr;
   logic [N-1:0]    accWdata;
   logic [NB-1:0]   accBe;
   logic [NB-1:0]   laneEn;
   logic [NB-1:0]   wrLanes;
   logic            good;
   logic [R-1:0]    idx;
   logic [N-1:0]    rdWord;
   logic [N-1:0]    merged;

   assign reqReady = (state_q == IDLE) && !rst;
   assign accept   = bus.req_valid && reqReady;

   // With no wait states the access happens on the accept edge, so it must use the live bus.
   assign fire     = ZeroWait ? accept : ((state_q == BUSY) && (cnt_q == '0));
   assign accWe    = ZeroWait ? bus.write_enable : we_q;
   assign accAddr  = ZeroWait ? bus.addr         : addr_q;
   assign accWdata = ZeroWait ? bus.writedata    : wdata_q;
   assign accBe    = ZeroWait ? bus.be           : be_q;

`ifdef DMEM_BYTE_WRITE_EN
   assign laneEn = accBe;
`else
   assign laneEn = '1;
`endif

   assign good    = (accAddr[B-1:0] == '0) && ((accAddr >> (R + B)) == '0);
   assign idx     = accAddr[R+B-1:B];
   assign wrLanes = {NB{fire && accWe && good && !rst}} & laneEn;

   always_comb begin
      merged = rdWord;
      for (int i = 0; i < NB; i++) begin
         if (accWe && laneEn[i]) merged[8*i +: 8] = accWdata[8*i +: 8];
      end
   end

   dmem_array #(
      .N (N),
      .R (R)
   ) uArray (
      .clk     (clk),
      .we_i    (wrLanes),
      .addr_i  (idx),
      .wdata_i (accWdata),
      .rdata_o (rdWord)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         respValid_q <= 1'b0;
         readData_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         respValid_q <= 1'b0;
         if (fire) begin
            respValid_q <= 1'b1;
            readData_q  <= good ? merged : '0;
            err_q       <= !good;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q    <= bus.write_enable;
                  addr_q  <= bus.addr;
                  wdata_q <= bus.writedata;
                  be_q    <= bus.be;
                  if (ZeroWait) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= cnt_t'(WAIT - 1);
                  end
               end
            end
            BUSY: begin
               if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
               else             state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = reqReady;
   assign bus.resp_valid = respValid_q;
   assign bus.readdata   = readData_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_dmem_wait.sv
// Scoreboard bench for dmem_wait: four instances (WAIT 0, 2, 15, 3) behind one driver.
module tb_dmem_wait;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   sel = 0;
   int   checks = 0;
   int   errors = 0;
   int   respSeen = 0;

   logic        tValid = 1'b0;
   logic        tWe    = 1'b0;
   logic [31:0] tAddr  = '0;
   logic [31:0] tWdata = '0;
   logic [3:0]  tBe    = '0;

   logic        mReady;
   logic        mResp;
   logic [31:0] mData;
   logic        mErr;

   exp_t        expQ[$];
   logic [31:0] model [4][64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_wait_if #(.N(32)) b0 ();
   dmem_wait_if #(.N(32)) b1 ();
   dmem_wait_if #(.N(32)) b2 ();
   dmem_wait_if #(.N(32)) b3 ();

   dmem_wait #(.N(32), .R(6), .WAIT(0))  u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   dmem_wait #(.N(32), .R(6), .WAIT(2))  u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   dmem_wait #(.N(32), .R(6), .WAIT(15)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
   dmem_wait #(.N(32), .R(6), .WAIT(3))  u3 (.clk(clk), .rst(rst), .bus(b3.slave));

   // One driver fans out to the selected instance; unselected instances see req_valid low.
   assign b0.req_valid = (sel == 0) && tValid;
   assign b1.req_valid = (sel == 1) && tValid;
   assign b2.req_valid = (sel == 2) && tValid;
   assign b3.req_valid = (sel == 3) && tValid;
   assign b0.write_enable = tWe;
   assign b1.write_enable = tWe;
   assign b2.write_enable = tWe;
   assign b3.write_enable = tWe;
   assign b0.addr = tAddr;
   assign b1.addr = tAddr;
   assign b2.addr = tAddr;
   assign b3.addr = tAddr;
   assign b0.writedata = tWdata;
   assign b1.writedata = tWdata;
   assign b2.writedata = tWdata;
   assign b3.writedata = tWdata;
   assign b0.be = tBe;
   assign b1.be = tBe;
   assign b2.be = tBe;
   assign b3.be = tBe;

   always_comb begin
      mReady = b0.req_ready;
      mResp  = b0.resp_valid;
      mData  = b0.readdata;
      mErr   = b0.err;
      case (sel)
         1: begin mReady = b1.req_ready; mResp = b1.resp_valid; mData = b1.readdata; mErr = b1.err; end
         2: begin mReady = b2.req_ready; mResp = b2.resp_valid; mData = b2.readdata; mErr = b2.err; end
         3: begin mReady = b3.req_ready; mResp = b3.resp_valid; mData = b3.readdata; mErr = b3.err; end
         default: ;
      endcase
   end

   function automatic int waitOf(input int inst);
      case (inst)
         0:       return 0;
         1:       return 2;
         2:       return 15;
         default: return 3;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one request, waits for acceptance, and pushes the model's answer to the scoreboard.
   task automatic applyStimulus(input int inst, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] b,
                                input bit expectResp, input bit hold, output int acceptCyc);
      int          budget;
      logic        good;
      logic [5:0]  idx;
      logic [3:0]  laneEn;
      logic [31:0] word;
      exp_t        e;
      sel    = inst;
      tValid = 1'b1;
      tWe    = we;
      tAddr  = a;
      tWdata = wd;
      tBe    = b;
      budget = 0;
      #1;
      while (!mReady && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (!mReady) begin
         checkOutput("accept_timeout", 32'(mReady), 32'd1);
         tValid    = 1'b0;
         acceptCyc = cyc;
         return;
      end
      acceptCyc = cyc;
`ifdef DMEM_BYTE_WRITE_EN
      laneEn = b;
`else
      laneEn = 4'hF;
`endif
      good = (a[1:0] == 2'b00) && (a[31:8] == 24'd0);
      idx  = a[7:2];
      word = model[inst][idx];
      if (!good) begin
         e.data = '0;
         e.err  = 1'b1;
      end else begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (laneEn[i]) word[8*i +: 8] = wd[8*i +: 8];
            end
            if (expectResp) model[inst][idx] = word;
         end
         e.data = word;
         e.err  = 1'b0;
      end
      e.cyc = acceptCyc + waitOf(inst) + 1;
      if (expectResp) expQ.push_back(e);
      @(negedge clk);
      if (!hold) tValid = 1'b0;
   endtask

   task automatic waitDrain();
      int budget;
      budget = 0;
      while (expQ.size() != 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (expQ.size() != 0) begin
         checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
   endtask

   always @(negedge clk) begin
      if (!rst && mResp) begin
         exp_t e;
         respSeen++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("resp_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("readdata", mData, e.data);
            checkOutput("err", 32'(mErr), 32'(e.err));
         end
      end
   end

   initial begin
      int t0;
      int t1;
      int seenBefore;

      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sel = i;
         #1;
         checkOutput("rst_ready", 32'(mReady), 32'd0);
         checkOutput("rst_resp_valid", 32'(mResp), 32'd0);
         checkOutput("rst_readdata", mData, 32'd0);
         checkOutput("rst_err", 32'(mErr), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sel = i;
         #1;
         checkOutput("ready_after_rst", 32'(mReady), 32'd1);
      end
      @(negedge clk);

      $display("[TB] full word write/read, WAIT=2");
      applyStimulus(1, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, t0);
      waitDrain();

      $display("[TB] byte lanes");
      applyStimulus(1, 1'b1, 32'h4, 32'h0000_0000, 4'hF, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b1, 32'h4, 32'h0000_FFFF, 4'h3, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b1, 32'h4, 32'hAB00_0000, 4'h8, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, t0);
      waitDrain();

      $display("[TB] error addresses and empty byte enable");
      applyStimulus(1, 1'b1, 32'h0000_0002, 32'h1234_5678, 4'hF, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b0, 32'h0000_0002, 32'h0, 4'hF, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, t0);
      applyStimulus(1, 1'b1, 32'h0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, t0);
      waitDrain();
      repeat (3) @(negedge clk);
      checkOutput("readdata_hold", mData, model[1][0]);
      checkOutput("resp_valid_idle", 32'(mResp), 32'd0);

      $display("[TB] latency sweep WAIT=0");
      applyStimulus(0, 1'b1, 32'hC, 32'h1122_3344, 4'hF, 1'b1, 1'b1, t0);
      applyStimulus(0, 1'b0, 32'hC, 32'h0, 4'hF, 1'b1, 1'b0, t1);
      checkOutput("throughput_w0", 32'(t1 - t0), 32'd2);
      waitDrain();

      $display("[TB] latency sweep WAIT=15");
      applyStimulus(2, 1'b1, 32'h10, 32'h5566_7788, 4'hF, 1'b1, 1'b1, t0);
      applyStimulus(2, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, t1);
      checkOutput("throughput_w15", 32'(t1 - t0), 32'd17);
      waitDrain();

      $display("[TB] reset during write, WAIT=3");
      applyStimulus(3, 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, t0);
      waitDrain();
      seenBefore = respSeen;
      applyStimulus(3, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 1'b0, 1'b0, t0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("no_resp_after_rst", 32'(respSeen - seenBefore), 32'd0);
      applyStimulus(3, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1, 1'b0, t0);
      waitDrain();

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
